// File: rtl/lif_neuron_if.sv
// Bus between a leaky integrate-and-fire neuron and whatever drives/observes it.
// master drives the synaptic inputs; slave is the neuron itself.
interface lif_neuron_if #(
  parameter int WEIGHT_W = 8,
  parameter int MEM_W    = 10
);
  logic                en;
  logic                pre_spike;
  logic [WEIGHT_W-1:0] weight;
  logic                post_spike;
  logic [MEM_W-1:0]    membrane;
  logic                refractory;
  logic [7:0]          spike_count;

  modport master (
    output en, pre_spike, weight,
    input  post_spike, membrane, refractory, spike_count
  );

  modport slave (
    input  en, pre_spike, weight,
    output post_spike, membrane, refractory, spike_count
  );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift-based leak, saturating integration,
// one-cycle post spike and a fixed-length refractory window after each fire.
module lif_neuron #(
  parameter int WEIGHT_W      = 8,
  parameter int MEM_W         = 10,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  lif_neuron_if.slave  bus
);
  localparam int SUM_W = ((WEIGHT_W > MEM_W) ? WEIGHT_W : MEM_W) + 1;
  localparam logic [SUM_W-1:0] VMAX = SUM_W'((1 << MEM_W) - 1);
  localparam logic [MEM_W-1:0] THR  = MEM_W'(THRESHOLD);
  localparam logic [3:0]       RCYC = 4'(REFRAC_CYCLES);

  typedef enum logic {INTEGRATE, REFRACT} state_t;

  state_t           state, state_nx;
  logic [MEM_W-1:0] v, v_nx;
  logic             post, post_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [7:0]       sc, sc_nx;

  logic [MEM_W-1:0] leak;
  logic [SUM_W-1:0] sum;
  logic [MEM_W-1:0] v_sat;
  logic             fire;

  // Leak never exceeds v, so the subtraction cannot underflow.
  always_comb begin
    leak = v >> LEAK_SHIFT;
    if (leak == '0 && v != '0) leak = MEM_W'(1);
    sum   = SUM_W'(v) - SUM_W'(leak) + (bus.pre_spike ? SUM_W'(bus.weight) : '0);
    v_sat = (sum > VMAX) ? VMAX[MEM_W-1:0] : sum[MEM_W-1:0];
    fire  = (v_sat >= THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INTEGRATE;
      v     <= '0;
      post  <= 1'b0;
      cnt   <= '0;
      sc    <= '0;
    end else begin
      state <= state_nx;
      v     <= v_nx;
      post  <= post_nx;
      cnt   <= cnt_nx;
      sc    <= sc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    v_nx     = v;
    post_nx  = 1'b0;
    cnt_nx   = cnt;
    sc_nx    = sc;
    if (bus.en) begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            v_nx    = '0;
            post_nx = 1'b1;
            sc_nx   = (sc == 8'hFF) ? sc : sc + 8'd1;
            if (REFRAC_CYCLES > 0) begin
              state_nx = REFRACT;
              cnt_nx   = RCYC;
            end
          end else begin
            v_nx = v_sat;
          end
        end
        REFRACT: begin
          v_nx = '0;
          if (cnt == 4'd1) begin
            state_nx = INTEGRATE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
        default: state_nx = INTEGRATE;
      endcase
    end
  end

  assign bus.post_spike  = post;
  assign bus.membrane    = v;
  assign bus.refractory  = (state == REFRACT);
  assign bus.spike_count = sc;
endmodule
